// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master (instruction fetch, data) to one-slave memory arbiter.
//
// A request is granted combinationally in IDLE. Its fields are registered and
// then run as one bus transfer (BUS). Completion is reported as a single
// rvalid pulse to the owner in DONE. The data port normally wins. A saturating
// counter of back-to-back data grants lets the fetch port through after
// MAX_CONSEC data grants in a row. Misaligned requests never reach the bus.
// A BUS cycle budget of TIMEOUT aborts transfers that the slave never
// acknowledges.
//
// Ports:
//   clk, reset_n                         clock, async active-low reset
//   if_req/if_addr -> if_gnt/if_rvalid/if_rdata/if_err         fetch port
//   d_req/d_we/d_be/d_addr/d_wdata -> d_gnt/d_rvalid/d_rdata/d_err  data port
//   m_req/m_we/m_be/m_addr/m_wdata <- m_ack/m_rdata            memory port
module mem_arbiter #(
  parameter int MAX_CONSEC = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        m_req,
  output logic        m_we,
  output logic [3:0]  m_be,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata
);

  localparam int            CW         = (MAX_CONSEC < 1) ? 1 : $clog2(MAX_CONSEC + 1);
  localparam logic [CW-1:0] CONSEC_MAX = CW'(MAX_CONSEC);
  localparam logic [7:0]    TOUT_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, DONE = 2'd2} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] consec_reg;
  logic [7:0]    tout_reg;
  logic          owner_d_reg;
  logic          m_req_reg, m_we_reg;
  logic [3:0]    m_be_reg;
  logic [31:0]   m_addr_reg, m_wdata_reg;
  logic          if_rvalid_reg, if_err_reg, d_rvalid_reg, d_err_reg;
  logic [31:0]   if_rdata_reg, d_rdata_reg;

  logic          sel_d, sel_i, gnt;
  logic          if_mis, d_mis, gnt_mis;
  logic          tout_hit, fin, fin_owner_d, fin_err;
  logic [31:0]   fin_rdata;

  // Alignment: full words need addr[1:0]=0, aligned halfwords need addr[0]=0.
  // Other byte-enable patterns are treated as byte accesses and always pass.
  assign if_mis  = (if_addr[1:0] != 2'b00);
  assign d_mis   = ((d_be == 4'b1111) && (d_addr[1:0] != 2'b00)) ||
                   (((d_be == 4'b0011) || (d_be == 4'b1100)) && d_addr[0]);
  assign gnt     = sel_d | sel_i;
  assign gnt_mis = sel_d ? d_mis : if_mis;

  // tout_reg counts completed BUS cycles, so hitting TIMEOUT-1 in the current
  // cycle means m_req has been high for exactly TIMEOUT cycles.
  assign tout_hit = (tout_reg == TOUT_LAST);

  // fin: the transaction completes this cycle and DONE follows. In IDLE that
  // only happens on a misaligned gnt, which is why IDLE completions are errors.
  assign fin         = ((state_reg == IDLE) && gnt && gnt_mis) ||
                       ((state_reg == BUS) && (m_ack || tout_hit));
  assign fin_owner_d = (state_reg == IDLE) ? sel_d : owner_d_reg;
  assign fin_err     = (state_reg != BUS) || !m_ack;
  assign fin_rdata   = (fin_err || m_we_reg) ? 32'h0 : m_rdata;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (gnt) state_next = gnt_mis ? DONE : BUS;
      BUS:     if (m_ack || tout_hit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: grants exist only in IDLE. Data wins unless the fetch port
  // has already watched MAX_CONSEC data grants go by.
  always_comb begin
    sel_d = 1'b0;
    sel_i = 1'b0;
    if (state_reg == IDLE) begin
      sel_d = d_req && !(if_req && (consec_reg == CONSEC_MAX));
      sel_i = if_req && !sel_d;
    end
  end

  assign if_gnt = sel_i;
  assign d_gnt  = sel_d;

  // Datapath and counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      consec_reg    <= '0;
      tout_reg      <= '0;
      owner_d_reg   <= 1'b0;
      m_req_reg     <= 1'b0;
      m_we_reg      <= 1'b0;
      m_be_reg      <= 4'b0000;
      m_addr_reg    <= 32'h0;
      m_wdata_reg   <= 32'h0;
      if_rvalid_reg <= 1'b0;
      if_err_reg    <= 1'b0;
      if_rdata_reg  <= 32'h0;
      d_rvalid_reg  <= 1'b0;
      d_err_reg     <= 1'b0;
      d_rdata_reg   <= 32'h0;
    end else begin
      if ((state_reg == IDLE) && gnt) begin
        owner_d_reg <= sel_d;
        m_we_reg    <= sel_d && d_we;
        m_be_reg    <= sel_d ? d_be : 4'b1111;
        m_addr_reg  <= sel_d ? {d_addr[31:2], 2'b00} : {if_addr[31:2], 2'b00};
        m_wdata_reg <= sel_d ? d_wdata : 32'h0;
        m_req_reg   <= !gnt_mis;
        tout_reg    <= '0;
        // Only data grants taken while the fetch port waits build up credit.
        if (sel_i || !if_req)
          consec_reg <= '0;
        else if (consec_reg != CONSEC_MAX)
          consec_reg <= consec_reg + 1'b1;
      end else if (state_reg == BUS) begin
        if (fin) m_req_reg <= 1'b0;
        else     tout_reg  <= tout_reg + 8'd1;
      end

      // rvalid is high only in the DONE cycle; rdata/err hold between pulses.
      if_rvalid_reg <= fin && !fin_owner_d;
      d_rvalid_reg  <= fin && fin_owner_d;
      if (fin) begin
        if (fin_owner_d) begin
          d_err_reg   <= fin_err;
          d_rdata_reg <= fin_rdata;
        end else begin
          if_err_reg   <= fin_err;
          if_rdata_reg <= fin_rdata;
        end
      end
    end
  end

  assign m_req     = m_req_reg;
  assign m_we      = m_we_reg;
  assign m_be      = m_be_reg;
  assign m_addr    = m_addr_reg;
  assign m_wdata   = m_wdata_reg;
  assign if_rvalid = if_rvalid_reg;
  assign if_rdata  = if_rdata_reg;
  assign if_err    = if_err_reg;
  assign d_rvalid  = d_rvalid_reg;
  assign d_rdata   = d_rdata_reg;
  assign d_err     = d_err_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter (MAX_CONSEC=4, TIMEOUT=8).
// Inputs change on the falling edge. Outputs are sampled 1 ns later, so the
// combinational grants reflect the current inputs. A small slave model raises
// m_ack ack_delay cycles into each bus request.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [3:0]  d_be = 4'h0;
  logic [31:0] d_addr = 32'h0, d_wdata = 32'h0;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        m_req, m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata;
  logic        m_ack = 1'b0;
  logic [31:0] m_rdata = 32'h0;

  int          n_checks = 0;
  int          n_fail = 0;
  int          ack_delay = 0;
  bit          ack_en = 1'b1;
  int          bus_cyc = 0;
  logic [31:0] resp_data = 32'h0;

  mem_arbiter #(.MAX_CONSEC(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  // Slave: acknowledges in the (ack_delay+1)-th cycle of a request.
  always @(negedge clk) begin
    if (m_req) begin
      m_ack   = ack_en && (bus_cyc == ack_delay);
      m_rdata = resp_data;
      bus_cyc = bus_cyc + 1;
    end else begin
      m_ack   = 1'b0;
      bus_cyc = 0;
    end
  end

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL reset_m_req: got %b want 0", m_req); end
    n_checks++; if (m_we !== 1'b0) begin n_fail++; $display("FAIL reset_m_we: got %b want 0", m_we); end
    n_checks++; if (m_be !== 4'h0) begin n_fail++; $display("FAIL reset_m_be: got %h want 0", m_be); end
    n_checks++; if (m_addr !== 32'h0) begin n_fail++; $display("FAIL reset_m_addr: got %h want 0", m_addr); end
    n_checks++; if (m_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_m_wdata: got %h want 0", m_wdata); end
    n_checks++; if ({if_rvalid, d_rvalid, if_err, d_err} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {if_rvalid, d_rvalid, if_err, d_err}); end
    n_checks++; if (if_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_if_rdata: got %h want 0", if_rdata); end
    n_checks++; if (d_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_d_rdata: got %h want 0", d_rdata); end
    n_checks++; if ({if_gnt, d_gnt} !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b want 00", {if_gnt, d_gnt}); end
    @(negedge clk);
    reset_n = 1'b1;
    $display("reset: outputs cleared");
  endtask

  task automatic test_fetch_read;
    int mreq_cyc = 0, rv_cnt = 0, rv_at = -1;
    @(negedge clk);
    ack_en = 1'b1; ack_delay = 2; resp_data = 32'h0000_0013;
    if_req = 1'b1; if_addr = 32'h8000_0004;
    #1;
    n_checks++; if ({if_gnt, d_gnt} !== 2'b10) begin n_fail++; $display("FAIL fetch_gnt: got %b want 10", {if_gnt, d_gnt}); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if_req = 1'b0;
      #1;
      if (m_req) begin
        mreq_cyc++;
        if (mreq_cyc == 1) begin
          n_checks++; if (i !== 0) begin n_fail++; $display("FAIL fetch_mreq_start: got cycle %0d want 0", i); end
          n_checks++; if (m_addr !== 32'h8000_0004) begin n_fail++; $display("FAIL fetch_m_addr: got %h want 80000004", m_addr); end
          n_checks++; if ({m_we, m_be} !== 5'b0_1111) begin n_fail++; $display("FAIL fetch_we_be: got %b want 01111", {m_we, m_be}); end
        end
      end
      if (if_rvalid) begin
        rv_cnt++; rv_at = i;
        n_checks++; if (if_rdata !== 32'h13) begin n_fail++; $display("FAIL fetch_rdata: got %h want 00000013", if_rdata); end
        n_checks++; if (if_err !== 1'b0) begin n_fail++; $display("FAIL fetch_err: got %b want 0", if_err); end
      end
      n_checks++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL fetch_d_rvalid: got %b want 0", d_rvalid); end
    end
    n_checks++; if (mreq_cyc !== 3) begin n_fail++; $display("FAIL fetch_mreq_cycles: got %0d want 3", mreq_cyc); end
    n_checks++; if (rv_cnt !== 1) begin n_fail++; $display("FAIL fetch_rvalid_count: got %0d want 1", rv_cnt); end
    n_checks++; if (rv_at !== 3) begin n_fail++; $display("FAIL fetch_rvalid_cycle: got %0d want 3", rv_at); end
    $display("fetch read 80000004: rdata=%h err=%b", if_rdata, if_err);
  endtask

  task automatic test_misaligned;
    int rv_cnt = 0, rv_at = -1;
    bit mreq_seen = 1'b0;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_be = 4'b1111; d_addr = 32'h0000_0102;
    #1;
    n_checks++; if ({if_gnt, d_gnt} !== 2'b01) begin n_fail++; $display("FAIL mis_gnt: got %b want 01", {if_gnt, d_gnt}); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      d_req = 1'b0;
      #1;
      if (m_req) mreq_seen = 1'b1;
      if (d_rvalid) begin
        rv_cnt++; rv_at = i;
        n_checks++; if (d_err !== 1'b1) begin n_fail++; $display("FAIL mis_err: got %b want 1", d_err); end
        n_checks++; if (d_rdata !== 32'h0) begin n_fail++; $display("FAIL mis_rdata: got %h want 0", d_rdata); end
      end
    end
    n_checks++; if (mreq_seen !== 1'b0) begin n_fail++; $display("FAIL mis_mreq: got 1 want 0"); end
    n_checks++; if (rv_cnt !== 1) begin n_fail++; $display("FAIL mis_rvalid_count: got %0d want 1", rv_cnt); end
    // gnt cycle then the DONE cycle, which carries the pulse
    n_checks++; if (rv_at !== 0) begin n_fail++; $display("FAIL mis_rvalid_cycle: got %0d want 0", rv_at); end
    n_checks++; if (d_err !== 1'b1) begin n_fail++; $display("FAIL mis_err_hold: got %b want 1", d_err); end
    $display("misaligned load 00000102: err=%b", d_err);
  endtask

  task automatic test_simultaneous;
    int rv_at = -1, if_at = -1;
    @(negedge clk);
    ack_delay = 0; resp_data = 32'hA5A5_0001;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'b1111; d_addr = 32'h0000_0100;
    if_req = 1'b1; if_addr = 32'h0000_0200;
    #1;
    n_checks++; if ({if_gnt, d_gnt} !== 2'b01) begin n_fail++; $display("FAIL simul_first_gnt: got %b want 01", {if_gnt, d_gnt}); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      d_req = 1'b0;
      if (if_at >= 0) if_req = 1'b0;
      #1;
      if (i == 0) begin
        n_checks++; if ({m_req, m_addr} !== {1'b1, 32'h0000_0100}) begin n_fail++; $display("FAIL simul_m_addr: got %b/%h want 1/00000100", m_req, m_addr); end
      end
      if (d_rvalid) begin
        rv_at = i;
        n_checks++; if (d_rdata !== 32'hA5A5_0001) begin n_fail++; $display("FAIL simul_d_rdata: got %h want a5a50001", d_rdata); end
      end
      if (if_gnt && if_at < 0) if_at = i;
    end
    n_checks++; if (rv_at !== 1) begin n_fail++; $display("FAIL simul_d_rvalid_cycle: got %0d want 1", rv_at); end
    n_checks++; if (if_at !== 2) begin n_fail++; $display("FAIL simul_if_gnt_cycle: got %0d want 2", if_at); end
    $display("simultaneous: d_rvalid at %0d, if_gnt at %0d", rv_at, if_at);
  endtask

  task automatic test_starvation;
    int k = 0;
    bit exp_d;
    @(negedge clk);
    ack_delay = 0; resp_data = 32'h1234_5678;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'b1111; d_addr = 32'h0000_0104;
    if_req = 1'b1; if_addr = 32'h0000_0008;
    for (int i = 0; i < 60 && k < 10; i++) begin
      #1;
      n_checks++; if ((if_gnt & d_gnt) !== 1'b0) begin n_fail++; $display("FAIL starve_both_gnt: got 1 want 0"); end
      if (if_gnt || d_gnt) begin
        exp_d = ((k % 5) != 4);
        n_checks++; if (d_gnt !== exp_d) begin n_fail++; $display("FAIL starve_order: grant %0d got %s want %s", k, d_gnt ? "D" : "I", exp_d ? "D" : "I"); end
        k++;
      end
      @(negedge clk);
    end
    d_req = 1'b0; if_req = 1'b0;
    n_checks++; if (k !== 10) begin n_fail++; $display("FAIL starve_grant_count: got %0d want 10", k); end
    repeat (4) @(negedge clk);
    $display("starvation: %0d grants observed", k);
  endtask

  task automatic test_timeout;
    int mreq_cyc = 0, rv_cnt = 0, rv_at = -1;
    @(negedge clk);
    ack_en = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b1111; d_addr = 32'h0000_0040; d_wdata = 32'hDEAD_BEEF;
    #1;
    n_checks++; if ({if_gnt, d_gnt} !== 2'b01) begin n_fail++; $display("FAIL tout_gnt: got %b want 01", {if_gnt, d_gnt}); end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      d_req = 1'b0;
      #1;
      if (m_req) begin
        mreq_cyc++;
        if (mreq_cyc == 1) begin
          n_checks++; if ({m_we, m_addr, m_wdata} !== {1'b1, 32'h0000_0040, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL tout_fields: got %b/%h/%h want 1/00000040/deadbeef", m_we, m_addr, m_wdata); end
        end
      end
      if (d_rvalid) begin
        rv_cnt++; rv_at = i;
        n_checks++; if (d_err !== 1'b1) begin n_fail++; $display("FAIL tout_err: got %b want 1", d_err); end
        n_checks++; if (d_rdata !== 32'h0) begin n_fail++; $display("FAIL tout_rdata: got %h want 0", d_rdata); end
      end
    end
    ack_en = 1'b1;
    n_checks++; if (mreq_cyc !== 8) begin n_fail++; $display("FAIL tout_mreq_cycles: got %0d want 8", mreq_cyc); end
    n_checks++; if (rv_cnt !== 1) begin n_fail++; $display("FAIL tout_rvalid_count: got %0d want 1", rv_cnt); end
    n_checks++; if (rv_at !== 8) begin n_fail++; $display("FAIL tout_rvalid_cycle: got %0d want 8", rv_at); end
    $display("timeout store 00000040: m_req cycles=%0d err=%b", mreq_cyc, d_err);
  endtask

  task automatic test_reset_mid;
    int rv_cnt = 0, mreq_cnt = 0;
    @(negedge clk);
    ack_en = 1'b0;
    if_req = 1'b1; if_addr = 32'h0000_0010;
    #1;
    n_checks++; if (if_gnt !== 1'b1) begin n_fail++; $display("FAIL rmid_gnt: got %b want 1", if_gnt); end
    @(negedge clk);
    if_req = 1'b0;
    @(negedge clk);
    #1;
    n_checks++; if (m_req !== 1'b1) begin n_fail++; $display("FAIL rmid_in_bus: got %b want 1", m_req); end
    reset_n = 1'b0;
    #1;
    n_checks++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL rmid_mreq_async: got %b want 0", m_req); end
    @(negedge clk);
    reset_n = 1'b1; ack_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (if_rvalid || d_rvalid) rv_cnt++;
      if (m_req) mreq_cnt++;
    end
    n_checks++; if (rv_cnt !== 0) begin n_fail++; $display("FAIL rmid_stale_rvalid: got %0d want 0", rv_cnt); end
    n_checks++; if (mreq_cnt !== 0) begin n_fail++; $display("FAIL rmid_stale_mreq: got %0d want 0", mreq_cnt); end
    @(negedge clk);
    ack_delay = 0; resp_data = 32'h0000_0055;
    if_req = 1'b1; if_addr = 32'h0000_0020;
    #1;
    n_checks++; if (if_gnt !== 1'b1) begin n_fail++; $display("FAIL rmid_regrant: got %b want 1", if_gnt); end
    rv_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if_req = 1'b0;
      #1;
      if (i == 0) begin
        n_checks++; if ({m_req, m_addr} !== {1'b1, 32'h0000_0020}) begin n_fail++; $display("FAIL rmid_m_addr: got %b/%h want 1/00000020", m_req, m_addr); end
      end
      if (if_rvalid) begin
        rv_cnt++;
        n_checks++; if ({if_err, if_rdata} !== {1'b0, 32'h0000_0055}) begin n_fail++; $display("FAIL rmid_rdata: got %b/%h want 0/00000055", if_err, if_rdata); end
      end
    end
    n_checks++; if (rv_cnt !== 1) begin n_fail++; $display("FAIL rmid_rvalid_count: got %0d want 1", rv_cnt); end
    $display("reset mid-transfer: abandoned, refetch rdata=%h", if_rdata);
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_misaligned();
    test_simultaneous();
    test_starvation();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
